// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush, bubble gating of control bits and a stall counter.
module pipe_stage_reg #(
   parameter int CTRL_W = 11,
   parameter int DATA_W = 111,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Handshake: a beat moves on a rising edge when valid && ready on that side;
   // a producer keeps valid and its payload stable until the beat is taken.

   logic              m_valid_q, m_valid_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic              s_valid_q, s_valid_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  stall_q,   stall_d;

   logic pop;
   logic push;

   assign pop  = m_valid_q && out_ready;
   assign push = in_valid && in_ready;

   always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_ctrl_d  = s_ctrl_q;
      s_data_d  = s_data_q;
      if (flush) begin
         // Squash drops every held entry and the same-cycle input; data is kept.
         m_valid_d = 1'b0;
         m_ctrl_d  = '0;
         s_valid_d = 1'b0;
         s_ctrl_d  = '0;
      end else if (pop && s_valid_q) begin
         m_valid_d = 1'b1;
         m_ctrl_d  = s_ctrl_q;
         m_data_d  = s_data_q;
         s_valid_d = 1'b0;
         s_ctrl_d  = '0;
      end else if (push && (!m_valid_q || pop)) begin
         m_valid_d = 1'b1;
         m_ctrl_d  = in_ctrl;
         m_data_d  = in_data;
      end else if (push && (SKID != 0)) begin
         s_valid_d = 1'b1;
         s_ctrl_d  = in_ctrl;
         s_data_d  = in_data;
      end else if (pop) begin
         m_valid_d = 1'b0;
         m_ctrl_d  = '0;
      end
   end

   assign in_ready_d = !s_valid_d;

   always_comb begin
      stall_d = stall_q;
      if (m_valid_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid_q  <= 1'b0;
         m_ctrl_q   <= '0;
         m_data_q   <= '0;
         s_valid_q  <= 1'b0;
         s_ctrl_q   <= '0;
         s_data_q   <= '0;
         in_ready_q <= 1'b1;
         stall_q    <= '0;
      end else begin
         m_valid_q  <= m_valid_d;
         m_ctrl_q   <= m_ctrl_d;
         m_data_q   <= m_data_d;
         s_valid_q  <= s_valid_d;
         s_ctrl_q   <= s_ctrl_d;
         s_data_q   <= s_data_d;
         in_ready_q <= in_ready_d;
         stall_q    <= stall_d;
      end
   end

   // With the skid entry, in_ready is a flop so upstream never sees out_ready.
   if (SKID != 0) begin : g_skid
      assign in_ready = in_ready_q;
   end else begin : g_noskid
      logic unused_in_ready_q;
      assign unused_in_ready_q = in_ready_q;
      assign in_ready = out_ready || !m_valid_q;
   end

   assign out_valid = m_valid_q;
   assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
   assign out_data  = m_data_q;
   assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance driven by a vector table and directed
// sequences, a single-entry instance for the combinational-ready path, both scoreboarded.
module tb_pipe_stage_reg;

   localparam int CTRL_W = 11;
   localparam int DATA_W = 111;
   localparam int CNT_W  = 16;
   localparam int CNT0_W = 4;
   localparam int W      = CTRL_W + DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // skid instance
   logic              iv1 = 0, fl1 = 0, ordy1 = 0;
   logic [CTRL_W-1:0] ic1 = '0;
   logic [DATA_W-1:0] id1 = '0;
   logic              ir1, ov1;
   logic [CTRL_W-1:0] oc1;
   logic [DATA_W-1:0] od1;
   logic [1:0]        occ1;
   logic [CNT_W-1:0]  stall1;

   // single-entry instance
   logic              iv0 = 0, fl0 = 0, ordy0 = 0;
   logic [CTRL_W-1:0] ic0 = '0;
   logic [DATA_W-1:0] id0 = '0;
   logic              ir0, ov0;
   logic [CTRL_W-1:0] oc0;
   logic [DATA_W-1:0] od0;
   logic [1:0]        occ0;
   logic [CNT0_W-1:0] stall0;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp0_q[$];
   logic [W-1:0] e1, e0;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
      .flush(fl1), .out_valid(ov1), .out_ready(ordy1), .out_ctrl(oc1), .out_data(od1),
      .occupancy(occ1), .stall_cnt(stall1));

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(CNT0_W)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
      .flush(fl0), .out_valid(ov0), .out_ready(ordy0), .out_ctrl(oc0), .out_data(od0),
      .occupancy(occ0), .stall_cnt(stall0));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction scoreboards: accepted beats queue up, delivered beats must match in order.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
      end else if (fl1) begin
         exp_q.delete();
      end else begin
         if (ov1 && ordy1) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL sb1_underflow: got %0h expected nothing", {oc1, od1});
            end else begin
               e1 = exp_q.pop_front();
               check("sb1_beat", {oc1, od1}, e1);
            end
         end
         if (iv1 && ir1) exp_q.push_back({ic1, id1});
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp0_q.delete();
      end else if (fl0) begin
         exp0_q.delete();
      end else begin
         if (ov0 && ordy0) begin
            if (exp0_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL sb0_underflow: got %0h expected nothing", {oc0, od0});
            end else begin
               e0 = exp0_q.pop_front();
               check("sb0_beat", {oc0, od0}, e0);
            end
         end
         if (iv0 && ir0) exp0_q.push_back({ic0, id0});
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("occ1_vs_sb", occ1, exp_q.size());
         check("in_ready1_vs_sb", ir1, exp_q.size() < 2);
         check("occ0_vs_sb", occ0, exp0_q.size());
      end
   end

   task automatic drive1(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                         input logic fl, input logic ordy);
      @(negedge clk);
      iv1 = iv; ic1 = ic; id1 = id; fl1 = fl; ordy1 = ordy;
   endtask

   typedef struct {
      logic              iv;
      logic [CTRL_W-1:0] ic;
      logic [DATA_W-1:0] id;
      logic              fl;
      logic              ordy;
      logic              ov;
      logic [CTRL_W-1:0] oc;
      logic [DATA_W-1:0] od;
      logic [1:0]        occ;
      logic              ir;
      logic [CNT_W-1:0]  stall;
   } vec_t;

   vec_t vecs [15];

   initial begin
      //            iv    ic       id       fl    ordy  ov    oc       od       occ   ir    stall
      vecs[0]  = '{1'b1, 11'h7FF, 111'h1, 1'b0, 1'b1, 1'b1, 11'h7FF, 111'h1, 2'd1, 1'b1, 16'd0};
      vecs[1]  = '{1'b1, 11'h7FF, 111'h2, 1'b0, 1'b1, 1'b1, 11'h7FF, 111'h2, 2'd1, 1'b1, 16'd0};
      vecs[2]  = '{1'b1, 11'h7FF, 111'h3, 1'b0, 1'b1, 1'b1, 11'h7FF, 111'h3, 2'd1, 1'b1, 16'd0};
      vecs[3]  = '{1'b0, 11'h000, 111'h0, 1'b0, 1'b1, 1'b0, 11'h000, 111'h3, 2'd0, 1'b1, 16'd0};
      vecs[4]  = '{1'b1, 11'h0A5, 111'hA, 1'b0, 1'b0, 1'b1, 11'h0A5, 111'hA, 2'd1, 1'b1, 16'd0};
      vecs[5]  = '{1'b1, 11'h15A, 111'hB, 1'b0, 1'b0, 1'b1, 11'h0A5, 111'hA, 2'd2, 1'b0, 16'd1};
      vecs[6]  = '{1'b1, 11'h111, 111'hC, 1'b0, 1'b0, 1'b1, 11'h0A5, 111'hA, 2'd2, 1'b0, 16'd2};
      vecs[7]  = '{1'b0, 11'h000, 111'h0, 1'b0, 1'b1, 1'b1, 11'h15A, 111'hB, 2'd1, 1'b1, 16'd2};
      vecs[8]  = '{1'b0, 11'h000, 111'h0, 1'b0, 1'b1, 1'b0, 11'h000, 111'hB, 2'd0, 1'b1, 16'd2};
      vecs[9]  = '{1'b1, 11'h0A5, 111'hA, 1'b0, 1'b0, 1'b1, 11'h0A5, 111'hA, 2'd1, 1'b1, 16'd2};
      vecs[10] = '{1'b1, 11'h15A, 111'hB, 1'b0, 1'b0, 1'b1, 11'h0A5, 111'hA, 2'd2, 1'b0, 16'd3};
      vecs[11] = '{1'b1, 11'h3C3, 111'hC, 1'b1, 1'b0, 1'b0, 11'h000, 111'hA, 2'd0, 1'b1, 16'd3};
      vecs[12] = '{1'b1, 11'h3C3, 111'hC, 1'b1, 1'b1, 1'b0, 11'h000, 111'hA, 2'd0, 1'b1, 16'd3};
      vecs[13] = '{1'b1, 11'h0F0, 111'hD, 1'b0, 1'b1, 1'b1, 11'h0F0, 111'hD, 2'd1, 1'b1, 16'd3};
      vecs[14] = '{1'b0, 11'h000, 111'h0, 1'b0, 1'b1, 1'b0, 11'h000, 111'hD, 2'd0, 1'b1, 16'd3};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", ov1, 1'b0);
      check("rst_out_ctrl", oc1, '0);
      check("rst_out_data", od1, '0);
      check("rst_occupancy", occ1, 2'd0);
      check("rst_stall_cnt", stall1, '0);
      check("rst_in_ready", ir1, 1'b1);
      check("rst_in_ready_noskid", ir0, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      // table-driven vectors on the skid instance
      for (int i = 0; i < 15; i++) begin
         drive1(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].fl, vecs[i].ordy);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", i), ov1, vecs[i].ov);
         check($sformatf("v%0d_out_ctrl", i), oc1, vecs[i].oc);
         check($sformatf("v%0d_out_data", i), od1, vecs[i].od);
         check($sformatf("v%0d_occupancy", i), occ1, vecs[i].occ);
         check($sformatf("v%0d_in_ready", i), ir1, vecs[i].ir);
         check($sformatf("v%0d_stall_cnt", i), stall1, vecs[i].stall);
      end
      drive1(1'b0, '0, '0, 1'b0, 1'b0);

      // single entry: combinational ready, pop+push on one edge without a bubble
      @(negedge clk);
      iv0 = 1'b1; ic0 = 11'h001; id0 = 111'h21; ordy0 = 1'b0;
      @(posedge clk);
      #1;
      check("ns_cap_valid", ov0, 1'b1);
      check("ns_cap_data", od0, 111'h21);
      check("ns_full_in_ready", ir0, 1'b0);
      @(negedge clk);
      ordy0 = 1'b1; ic0 = 11'h002; id0 = 111'h22;
      #1;
      check("ns_comb_in_ready", ir0, 1'b1);
      @(posedge clk);
      #1;
      check("ns_nobubble_valid", ov0, 1'b1);
      check("ns_nobubble_data", od0, 111'h22);
      check("ns_nobubble_ctrl", oc0, 11'h002);
      @(negedge clk);
      iv0 = 1'b0; ordy0 = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("ns_stall_sat", stall0, 4'hF);
      @(negedge clk);
      fl0 = 1'b1; iv0 = 1'b1; ic0 = 11'h7FF; id0 = 111'h23; ordy0 = 1'b1;
      @(posedge clk);
      #1;
      check("ns_flush_valid", ov0, 1'b0);
      check("ns_flush_ctrl", oc0, '0);
      check("ns_flush_occ", occ0, 2'd0);
      @(negedge clk);
      fl0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b0;
      #1;
      check("ns_flush_in_ready", ir0, 1'b1);
      check("ns_flush_stall_kept", stall0, 4'hF);

      // stall counter saturation on the skid instance
      drive1(1'b1, 11'h055, 111'h5A, 1'b0, 1'b0);
      drive1(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (70000) @(posedge clk);
      #1;
      check("stall_saturated", stall1, 16'hFFFF);
      @(posedge clk);
      #1;
      check("stall_no_wrap", stall1, 16'hFFFF);
      check("stall_hold_data", od1, 111'h5A);

      // asynchronous reset while full
      drive1(1'b1, 11'h066, 111'h6B, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_occ", occ1, 2'd2);
      @(negedge clk);
      iv1 = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("arst_out_valid", ov1, 1'b0);
      check("arst_out_ctrl", oc1, '0);
      check("arst_out_data", od1, '0);
      check("arst_occ", occ1, 2'd0);
      check("arst_stall", stall1, '0);
      check("arst_in_ready", ir1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      drive1(1'b1, 11'h123, 111'hE, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("post_rst_valid", ov1, 1'b1);
      check("post_rst_data", od1, 111'hE);
      check("post_rst_ctrl", oc1, 11'h123);
      drive1(1'b0, '0, '0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("drain_valid", ov1, 1'b0);
      check("drain_ctrl", oc1, '0);
      check("sb1_empty", exp_q.size(), 0);
      check("sb0_empty", exp0_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
